// File: rtl/cpu19_pkg.sv
// Shared definitions for the cpu19 front end: PC mux encoding, sequencer
// states and the default register-index width.
package cpu19_pkg;

   localparam int REG_W_DEF = 4;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_IMM = 2'b01;
   localparam logic [1:0] PC_SP  = 2'b10;
   localparam logic [1:0] PC_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LSTALL = 2'd1,
      ST_HALT   = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // count up on inc, stick at all-ones, clear wins
   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Front-end pipeline sequencer: stall / flush / PC-source decisions for
// fetch and decode, with debug counters for stall cycles and redirects.
//
// state  | meaning
// RUN    | normal flow; redirects, load-use hazards and HALT evaluated
// LSTALL | extra load-use bubbles being inserted (bubble counter > 0)
// HALT   | core parked on a HALT in D until resume or an EX redirect
module fetch_hazard_ctrl
   import cpu19_pkg::*;
#(
   parameter int REG_W    = REG_W_DEF,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       jumpE,
   input  logic             mem_readE,
   input  logic [REG_W-1:0] rdE,
   input  logic [REG_W-1:0] rs1D,
   input  logic [REG_W-1:0] rs2D,
   input  logic             halt_reqD,
   input  logic             resume,
   output logic [1:0]       pc_sel,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic             halted,
   output logic             err_jump,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [3:0] BUB_INIT = 4'(LOAD_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] bub_q, bub_d;
   logic       redirect;
   logic       hazard;

   assign redirect = (jumpE == PC_IMM) || (jumpE == PC_SP);
   assign hazard   = mem_readE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
   assign halted   = (state_q == ST_HALT);

   // state and bubble-counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         bub_q   <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
      end
   end

   // next state: redirect beats everything, hazard only looked at in RUN
   always_comb begin
      state_d = state_q;
      bub_d   = bub_q;
      if (redirect) begin
         state_d = ST_RUN;
         bub_d   = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (hazard) begin
                  if (LOAD_LAT > 1) begin
                     state_d = ST_LSTALL;
                     bub_d   = BUB_INIT;
                  end
               end else if (halt_reqD) begin
                  state_d = ST_HALT;
               end
            end
            ST_LSTALL: begin
               bub_d = bub_q - 4'd1;
               if (bub_q <= 4'd1)
                  state_d = ST_RUN;
            end
            ST_HALT: begin
               if (resume)
                  state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Mealy pipeline controls; everything forced low while in reset
   always_comb begin
      pc_sel = PC_SEQ;
      stallF = 1'b0;
      stallD = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      if (!rst) begin
         if (redirect) begin
            pc_sel = jumpE;
            flushD = 1'b1;
            flushE = 1'b1;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (hazard || halt_reqD) begin
                     stallF = 1'b1;
                     stallD = 1'b1;
                     flushE = 1'b1;
                  end
               end
               ST_LSTALL: begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushE = 1'b1;
               end
               ST_HALT: begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushE = 1'b1;
                  // the HALT sitting in F/D is dropped on the way out
                  flushD = resume;
               end
               default: ;
            endcase
         end
      end
   end

   // sticky flag for the reserved jump encoding
   always_ff @(posedge clk) begin
      if (rst)
         err_jump <= 1'b0;
      else if (jumpE == PC_RSV)
         err_jump <= 1'b1;
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (stallF),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (redirect),
      .cnt (flush_cnt)
   );

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Pipeline sequencer for the 19-bit CPU front end.
- Decides each cycle whether fetch/decode advance, stall or flush, and which PC source the fetch mux takes: PC+4, branch target immextE, or return address sp.
- Handles load-use stalls, EX-stage redirects and HALT/resume; keeps saturating stall and flush counters for debug.

Parameters:
- REG_W, 4, register-index width of rs1D/rs2D/rdE.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- jumpE  in  2  EX redirect: 00 none, 01 immextE target, 10 sp target, 11 reserved.
- mem_readE  in  1  instruction in EX is a load.
- rdE  in  REG_W  destination of the EX instruction.
- rs1D  in  REG_W  source 1 of the D instruction.
- rs2D  in  REG_W  source 2 of the D instruction.
- halt_reqD  in  1  D instruction is HALT.
- resume  in  1  external resume pulse.
- pc_sel  out  2  fetch PC mux select, same encoding as jumpE.
- stallF  out  1  hold PC.
- stallD  out  1  hold the F/D register.
- flushD  out  1  zero the F/D instruction.
- flushE  out  1  insert a bubble into D/E.
- halted  out  1  core is in HALT.
- err_jump  out  1  sticky: jumpE=11 was seen.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of redirects.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state RUN, bubble counter 0, all outputs 0.
- Timing split: stall, flush and pc_sel are combinational (Mealy) from state and inputs, so they act in the same cycle. State, counters and err_jump are registered.
- States: RUN, LSTALL, HALT.
- Redirect condition: jumpE is 01 or 10.
  - pc_sel = jumpE, flushD = 1, flushE = 1. stallF and stallD are not asserted.
  - Next state is RUN, whatever the current state.
  - flush_cnt increments.
  - A redirect has the highest priority after rst.
- jumpE = 11: treated as 00, pc_sel = 00, err_jump is set. err_jump clears only on rst.
- Load-use hazard condition, evaluated in RUN: mem_readE && rdE != 0 && (rdE == rs1D || rdE == rs2D).
  - Without a redirect: stallF = stallD = flushE = 1.
  - If LOAD_LAT > 1, go to LSTALL with bubble counter = LOAD_LAT-1.
  - If LOAD_LAT = 1, stay in RUN.
- LSTALL:
  - stallF = stallD = flushE = 1 every cycle.
  - Counter decrements; when it reaches 0, go to RUN.
  - The hazard is not re-evaluated while in LSTALL.
- halt_reqD in RUN, with no redirect and no hazard that cycle:
  - stallF = stallD = 1, flushE = 1 (HALT does not enter EX).
  - Next state is HALT.
- HALT:
  - stallF = stallD = flushE = 1, halted = 1.
  - resume → RUN next cycle; the HALT in D is then discarded: flushD = 1 for that cycle only.
  - A redirect in HALT (only possible from an older EX instruction) takes priority and exits to RUN.
- Same-cycle priority: rst > redirect > load-use > halt_reqD. Lower-priority requests are dropped that cycle and re-evaluated the next cycle, since D is held.
- stall_cnt increments in every cycle where stallF = 1, including HALT.
- Both counters saturate at all-ones and never wrap.
- rst mid-LSTALL or mid-HALT forces RUN in the next cycle with the counters cleared.
- rdE = 0 never causes a hazard (r0 is hardwired).

Decomposition:
- Shared package cpu19_pkg holds:
  - the pc_sel/jump encoding constants PC_SEQ=2'b00, PC_IMM=2'b01, PC_SP=2'b10;
  - the state enum;
  - the REG_W default.
- One sub-module: sat_counter (parameter CNT_W, inputs inc and clr), instantiated twice, once for stall_cnt and once for flush_cnt.

Test Plan:
- Reset: assert rst for 2 cycles with jumpE=01 held → all outputs 0, state RUN, counters 0.
- Redirect: jumpE=10 for 1 cycle → pc_sel=10, flushD=flushE=1, stallF=0, flush_cnt=1; the next cycle pc_sel=00.
- Load-use, LOAD_LAT=3: mem_readE=1, rdE=5, rs2D=5 → stallF=stallD=flushE=1 for exactly 3 cycles, stall_cnt=3. A repeat with rdE=0 gives no stall.
- Simultaneous events: redirect + hazard + halt_reqD in one cycle → redirect only: flushD=1, stallF=0, halted stays 0.
- HALT: halt_reqD=1 → halted=1 from the next cycle. 10 idle cycles → stall_cnt=11. resume → RUN, with flushD=1 for one cycle.
- Reserved encoding and saturation: jumpE=11 → pc_sel=00, err_jump=1 until rst. With CNT_W=4, 20 redirects → flush_cnt=15.
